// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types, oversample ratio and baud divider helper
package uart_pkg;

    localparam int OVERSAMPLE = 16;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_t;

    // Rounded clocks per oversample tick, shared by receiver and transmitter
    function automatic int calc_tick_div(input int clk, input int baud);
        return (clk + baud * (OVERSAMPLE / 2)) / (baud * OVERSAMPLE);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - 16x oversample tick generator with phase-align clear
module uart_baud_tick #(
    parameter int TICK_DIV = 1
) (
    input  logic clk_sys,
    input  logic rst_n,
    input  logic clear,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = (cnt == LAST);

    always_ff @(posedge clk_sys) begin
        if (!rst_n || clear) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with one-entry valid/ready output buffer
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 25000000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk_sys,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int TICK_DIV = calc_tick_div(CLK_FREQ, BAUD_RATE);

    if (TICK_DIV < 1) begin : g_bad_tick_div
        $error("uart_rx: clock too slow for requested baud rate");
    end

    logic      rxd_m;
    logic      rxd_s;
    rx_state_t state;
    logic [3:0] scnt;
    logic [2:0] bit_idx;
    logic [7:0] shreg;
    logic      s7;
    logic      s8;
    logic      tick;
    logic      tick_clear;
    logic      maj;

    // Restart the tick phase on the start edge so samples land mid-bit
    assign tick_clear = (state == IDLE) && !rxd_s;
    assign maj        = (s7 & s8) | (s7 & rxd_s) | (s8 & rxd_s);
    assign busy       = (state != IDLE);

    uart_baud_tick #(
        .TICK_DIV(TICK_DIV)
    ) u_baud_tick (
        .clk_sys(clk_sys),
        .rst_n  (rst_n),
        .clear  (tick_clear),
        .tick   (tick)
    );

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!rst_n) begin
            state     <= IDLE;
            scnt      <= 4'd0;
            bit_idx   <= 3'd0;
            shreg     <= 8'd0;
            s7        <= 1'b1;
            s8        <= 1'b1;
            rx_data   <= 8'd0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (!rxd_s) begin
                        state <= START;
                        scnt  <= 4'd0;
                    end
                end
                BREAK: begin
                    if (rxd_s) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    if (tick) begin
                        scnt <= scnt + 4'd1;
                        if (scnt == 4'd7) s7 <= rxd_s;
                        if (scnt == 4'd8) s8 <= rxd_s;
                        case (state)
                            START: begin
                                if (scnt == 4'd9 && maj) begin
                                    state <= IDLE;
                                end else if (scnt == 4'd15) begin
                                    state   <= DATA;
                                    bit_idx <= 3'd0;
                                end
                            end
                            DATA: begin
                                if (scnt == 4'd9) begin
                                    shreg <= {maj, shreg[7:1]};
                                end
                                if (scnt == 4'd15) begin
                                    if (bit_idx == 3'd7) state <= STOP;
                                    bit_idx <= bit_idx + 3'd1;
                                end
                            end
                            STOP: begin
                                // Return at mid stop bit to be ready for an early next start
                                if (scnt == 4'd9) begin
                                    if (maj) begin
                                        state <= IDLE;
                                        if (!rx_valid || rx_ready) begin
                                            rx_data  <= shreg;
                                            rx_valid <= 1'b1;
                                        end else begin
                                            overrun <= 1'b1;
                                        end
                                    end else begin
                                        frame_err <= 1'b1;
                                        state     <= BREAK;
                                    end
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx
module tb_uart_rx;

    logic       clk_sys = 1'b0;
    logic       rst_n;
    logic       rxd;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;
    int n_xfer   = 0;
    int n_fe     = 0;
    int n_ov     = 0;
    logic [7:0] sb[$];

    uart_rx #(
        .CLK_FREQ (1600000),
        .BAUD_RATE(100000)
    ) dut (
        .clk_sys  (clk_sys),
        .rst_n    (rst_n),
        .rxd      (rxd),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .frame_err(frame_err),
        .overrun  (overrun),
        .busy     (busy)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_clk(input int n);
        repeat (n) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    // Bit edges placed at floor(k * period) so fractional rates stay accurate over the frame
    task automatic send_frame(input logic [7:0] b, input logic stop, input int per_x100);
        logic [9:0] bits;
        int t_prev;
        int t_next;
        bits   = {stop, b, 1'b0};
        t_prev = 0;
        for (int k = 0; k < 10; k++) begin
            rxd    = bits[k];
            t_next = ((k + 1) * per_x100) / 100;
            wait_clk(t_next - t_prev);
            t_prev = t_next;
        end
    endtask

    always @(negedge clk_sys) begin
        if (rst_n === 1'b1) begin
            if (frame_err) n_fe++;
            if (overrun) n_ov++;
            if (rx_valid && rx_ready) begin
                n_xfer++;
                check("xfer_expected", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    check("rx_data", 32'(rx_data), 32'(sb.pop_front()));
                end
            end
        end
    end

    initial begin
        int x0;
        int f0;
        int o0;
        logic [7:0] b;

        rst_n    = 1'b0;
        rxd      = 1'b1;
        rx_ready = 1'b1;
        wait_clk(3);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        rst_n = 1'b1;
        wait_clk(5);

        // Nominal frame
        x0 = n_xfer; f0 = n_fe; o0 = n_ov;
        sb.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 1600);
        check("a5_busy_low", 32'(busy), 32'd0);
        wait_clk(4);
        check("a5_xfers", 32'(n_xfer - x0), 32'd1);
        check("a5_frame_err", 32'(n_fe - f0), 32'd0);
        check("a5_overrun", 32'(n_ov - o0), 32'd0);

        // False start
        x0 = n_xfer; f0 = n_fe;
        rxd = 1'b0;
        wait_clk(4);
        rxd = 1'b1;
        check("glitch_busy_high", 32'(busy), 32'd1);
        wait_clk(12);
        check("glitch_busy_low", 32'(busy), 32'd0);
        wait_clk(30);
        check("glitch_xfers", 32'(n_xfer - x0), 32'd0);
        check("glitch_frame_err", 32'(n_fe - f0), 32'd0);

        // Bad stop bit followed by break
        x0 = n_xfer; f0 = n_fe;
        send_frame(8'h3C, 1'b0, 1600);
        wait_clk(100);
        check("break_busy", 32'(busy), 32'd1);
        check("break_frame_err", 32'(n_fe - f0), 32'd1);
        check("break_xfers", 32'(n_xfer - x0), 32'd0);
        rxd = 1'b1;
        wait_clk(4);
        check("break_exit", 32'(busy), 32'd0);
        wait_clk(16);
        sb.push_back(8'h81);
        send_frame(8'h81, 1'b1, 1600);
        wait_clk(4);
        check("break_81_xfer", 32'(n_xfer - x0), 32'd1);
        check("break_fe_once", 32'(n_fe - f0), 32'd1);

        // Overrun with stalled consumer
        rx_ready = 1'b0;
        x0 = n_xfer; o0 = n_ov;
        sb.push_back(8'h11);
        send_frame(8'h11, 1'b1, 1600);
        wait_clk(2);
        send_frame(8'h22, 1'b1, 1600);
        wait_clk(2);
        check("ovr_pulses", 32'(n_ov - o0), 32'd1);
        check("ovr_valid", 32'(rx_valid), 32'd1);
        check("ovr_data_kept", 32'(rx_data), 32'h11);
        rx_ready = 1'b1;
        wait_clk(3);
        check("ovr_valid_drop", 32'(rx_valid), 32'd0);
        check("ovr_xfers", 32'(n_xfer - x0), 32'd1);

        // Consume on the exact delivery cycle
        rx_ready = 1'b0;
        x0 = n_xfer; o0 = n_ov;
        sb.push_back(8'h44);
        send_frame(8'h44, 1'b1, 1600);
        wait_clk(4);
        sb.push_back(8'h55);
        fork
            send_frame(8'h55, 1'b1, 1600);
            begin
                wait_clk(156);
                rx_ready = 1'b1;
                wait_clk(1);
                rx_ready = 1'b0;
            end
        join
        check("sim_overrun", 32'(n_ov - o0), 32'd0);
        check("sim_valid", 32'(rx_valid), 32'd1);
        check("sim_data", 32'(rx_data), 32'h55);
        check("sim_old_taken", 32'(n_xfer - x0), 32'd1);
        rx_ready = 1'b1;
        for (int i = 0; i < 10 && rx_valid; i++) wait_clk(1);
        check("sim_drain", 32'(rx_valid), 32'd0);

        // Baud tolerance +2% then -2%
        x0 = n_xfer; f0 = n_fe; o0 = n_ov;
        for (int i = 0; i < 256; i++) begin
            b = 8'($urandom);
            sb.push_back(b);
            send_frame(b, 1'b1, 1632);
        end
        for (int i = 0; i < 256; i++) begin
            b = 8'($urandom);
            sb.push_back(b);
            send_frame(b, 1'b1, 1568);
        end
        wait_clk(4);
        check("tol_xfers", 32'(n_xfer - x0), 32'd512);
        check("tol_frame_err", 32'(n_fe - f0), 32'd0);
        check("tol_overrun", 32'(n_ov - o0), 32'd0);

        // Reset mid-frame with a byte buffered
        rx_ready = 1'b0;
        send_frame(8'h99, 1'b1, 1600);
        wait_clk(2);
        check("mid_buffered", 32'(rx_valid), 32'd1);
        rxd = 1'b0;
        wait_clk(16);
        for (int k = 0; k < 4; k++) begin
            rxd = 1'b1;
            wait_clk(16);
        end
        rxd = 1'b0;
        wait_clk(8);
        check("mid_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        wait_clk(1);
        rst_n = 1'b1;
        check("mid_busy_after", 32'(busy), 32'd0);
        check("mid_valid_after", 32'(rx_valid), 32'd0);
        rxd = 1'b1;
        wait_clk(30);
        rx_ready = 1'b1;
        x0 = n_xfer;
        sb.push_back(8'h7E);
        send_frame(8'h7E, 1'b1, 1600);
        wait_clk(4);
        check("mid_7e_xfer", 32'(n_xfer - x0), 32'd1);
        check("sb_empty_end", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
